// File: rtl/riesgos_pkg.sv
// Shared definitions for the hazard/stall controller: FSM state encoding,
// default register-specifier width and the pipeline-control output bundles.
package riesgos_pkg;

    localparam int REG_W_DEF = 4;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } estado_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_bubble;
        logic freeze;
    } ctrl_t;

    // NOP control: front end held, NOPs injected into IF/ID and ID/EX.
    localparam ctrl_t CTRL_NOP = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1,
                                   idex_bubble: 1'b1, freeze: 1'b0};
    localparam ctrl_t CTRL_RUN = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                   idex_bubble: 1'b0, freeze: 1'b0};
    localparam ctrl_t CTRL_STALL = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                     idex_bubble: 1'b1, freeze: 1'b0};
    localparam ctrl_t CTRL_HOLD = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                    idex_bubble: 1'b0, freeze: 1'b1};
    localparam ctrl_t CTRL_BRANCH = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1,
                                      idex_bubble: 1'b1, freeze: 1'b0};

endpackage

// File: rtl/detector_dependencia.sv
// Load-use dependency comparator: flags an ID-stage source that matches the
// destination of a load currently in EXE.
module detector_dependencia
    import riesgos_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] i_rp_dec,
    input  logic [REG_W-1:0] i_rs_dec,
    input  logic             i_usa_rp_dec,
    input  logic             i_usa_rs_dec,
    input  logic [REG_W-1:0] i_rg_exe,
    input  logic             i_es_load_exe,
    input  logic             i_prohib_exe,
    output logic             o_hz
);

    logic w_match_rp;
    logic w_match_rs;

    assign w_match_rp = i_usa_rp_dec & (i_rp_dec == i_rg_exe);
    assign w_match_rs = i_usa_rs_dec & (i_rs_dec == i_rg_exe);
    assign o_hz       = i_es_load_exe & ~i_prohib_exe & (w_match_rp | w_match_rs);

endmodule

// File: rtl/unidad_de_riesgos.sv
// Hazard and stall controller for the IF/ID/EXE/MEM/WB pipeline (load-use,
// multi-cycle memory, taken branch). Optional macro: RIESGOS_MEM_TIMEOUT_EN.
module unidad_de_riesgos
    import riesgos_pkg::*;
#(
    parameter int REG_W       = REG_W_DEF,
    parameter int LOAD_LAT    = 1,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] RP_dec,
    input  logic [REG_W-1:0] RS_dec,
    input  logic             usa_RP_dec,
    input  logic             usa_RS_dec,
    input  logic [REG_W-1:0] RG_exe,
    input  logic             es_load_exe,
    input  logic             prohib_exe,
    input  logic             salto_exe,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             freeze,
    output logic [1:0]       estado,
    output logic             mem_err
);

    localparam logic [1:0] CNT_INI   = 2'(LOAD_LAT - 1);
    localparam bit         TMO_VALID = (MEM_TIMEOUT > 0) && (MEM_TIMEOUT < 256);

    estado_t    r_estado;
    estado_t    w_estado_next;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_next;
    ctrl_t      w_ctrl;
    logic       w_hz;
    logic       w_mw;
    logic       w_tmo;

    detector_dependencia #(
        .REG_W(REG_W)
    ) u_detector (
        .i_rp_dec     (RP_dec),
        .i_rs_dec     (RS_dec),
        .i_usa_rp_dec (usa_RP_dec),
        .i_usa_rs_dec (usa_RS_dec),
        .i_rg_exe     (RG_exe),
        .i_es_load_exe(es_load_exe),
        .i_prohib_exe (prohib_exe),
        .o_hz         (w_hz)
    );

    assign w_mw = mem_req & ~mem_ack;

`ifdef RIESGOS_MEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LIM = 8'(MEM_TIMEOUT - 1);

    logic [7:0] r_tmo_cnt;
    logic       r_mem_err;

    // The abort fires on the MEM_TIMEOUT-th consecutive unacknowledged wait cycle.
    assign w_tmo = TMO_VALID & (r_estado == MEM_WAIT) & w_mw & (r_tmo_cnt == TMO_LIM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tmo_cnt <= 8'd0;
            r_mem_err <= 1'b0;
        end else begin
            if (r_estado == MEM_WAIT && !w_tmo) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end else begin
                r_tmo_cnt <= 8'd0;
            end
            if (w_tmo) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    assign mem_err = r_mem_err;
`else
    assign w_tmo   = 1'b0;
    assign mem_err = 1'b0 & TMO_VALID;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_estado <= RUN;
            r_cnt    <= 2'd0;
        end else begin
            r_estado <= w_estado_next;
            r_cnt    <= w_cnt_next;
        end
    end

    always_comb begin
        w_ctrl        = CTRL_RUN;
        w_estado_next = r_estado;
        w_cnt_next    = r_cnt;

        case (r_estado)
            RUN: begin
                if (w_mw) begin
                    w_ctrl        = CTRL_HOLD;
                    w_estado_next = MEM_WAIT;
                end else if (salto_exe) begin
                    // The dependent instruction is flushed, so a pending hz is moot.
                    w_ctrl = CTRL_BRANCH;
                end else if (w_hz) begin
                    w_ctrl     = CTRL_STALL;
                    w_cnt_next = CNT_INI;
                    if (LOAD_LAT > 1) begin
                        w_estado_next = LOAD_STALL;
                    end
                end
            end

            LOAD_STALL: begin
                if (w_mw) begin
                    w_ctrl        = CTRL_HOLD;
                    w_estado_next = MEM_WAIT;
                end else begin
                    w_ctrl     = CTRL_STALL;
                    w_cnt_next = r_cnt - 2'd1;
                    if (r_cnt <= 2'd1) begin
                        w_cnt_next    = 2'd0;
                        w_estado_next = RUN;
                    end
                end
            end

            MEM_WAIT: begin
                w_ctrl = CTRL_HOLD;
                if (mem_req && mem_ack) begin
                    w_estado_next = (r_cnt != 2'd0) ? LOAD_STALL : RUN;
                end else if (!mem_req) begin
                    w_estado_next = RUN;
                    w_cnt_next    = 2'd0;
                end else if (w_tmo) begin
                    w_ctrl        = CTRL_NOP;
                    w_estado_next = RUN;
                    w_cnt_next    = 2'd0;
                end
            end

            default: begin
                w_ctrl        = CTRL_NOP;
                w_estado_next = RUN;
                w_cnt_next    = 2'd0;
            end
        endcase

        if (!rst_n) begin
            w_ctrl = CTRL_NOP;
        end
    end

    assign pc_en       = w_ctrl.pc_en;
    assign ifid_en     = w_ctrl.ifid_en;
    assign ifid_flush  = w_ctrl.ifid_flush;
    assign idex_bubble = w_ctrl.idex_bubble;
    assign freeze      = w_ctrl.freeze;
    assign estado      = rst_n ? r_estado : RUN;

endmodule

// File: tb/tb_unidad_de_riesgos.sv
// Directed bench: u0 uses LOAD_LAT=1, u3 uses LOAD_LAT=3 / MEM_TIMEOUT=4; both share stimulus.
module tb_unidad_de_riesgos;

    logic       clk;
    logic       rst_n;
    logic [3:0] RP_dec, RS_dec, RG_exe;
    logic       usa_RP_dec, usa_RS_dec, es_load_exe, prohib_exe, salto_exe;
    logic       mem_req, mem_ack;

    logic       pc_en0, ifid_en0, ifid_flush0, idex_bubble0, freeze0, mem_err0;
    logic [1:0] estado0;
    logic       pc_en3, ifid_en3, ifid_flush3, idex_bubble3, freeze3, mem_err3;
    logic [1:0] estado3;

    int n_assert = 0;
    int n_fail   = 0;
    int n_stall  = 0;

    unidad_de_riesgos #(.REG_W(4), .LOAD_LAT(1), .MEM_TIMEOUT(255)) u0 (
        .clk(clk), .rst_n(rst_n), .RP_dec(RP_dec), .RS_dec(RS_dec),
        .usa_RP_dec(usa_RP_dec), .usa_RS_dec(usa_RS_dec), .RG_exe(RG_exe),
        .es_load_exe(es_load_exe), .prohib_exe(prohib_exe), .salto_exe(salto_exe),
        .mem_req(mem_req), .mem_ack(mem_ack), .pc_en(pc_en0), .ifid_en(ifid_en0),
        .ifid_flush(ifid_flush0), .idex_bubble(idex_bubble0), .freeze(freeze0),
        .estado(estado0), .mem_err(mem_err0)
    );

    unidad_de_riesgos #(.REG_W(4), .LOAD_LAT(3), .MEM_TIMEOUT(4)) u3 (
        .clk(clk), .rst_n(rst_n), .RP_dec(RP_dec), .RS_dec(RS_dec),
        .usa_RP_dec(usa_RP_dec), .usa_RS_dec(usa_RS_dec), .RG_exe(RG_exe),
        .es_load_exe(es_load_exe), .prohib_exe(prohib_exe), .salto_exe(salto_exe),
        .mem_req(mem_req), .mem_ack(mem_ack), .pc_en(pc_en3), .ifid_en(ifid_en3),
        .ifid_flush(ifid_flush3), .idex_bubble(idex_bubble3), .freeze(freeze3),
        .estado(estado3), .mem_err(mem_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        RP_dec = 4'd0; RS_dec = 4'd0; RG_exe = 4'd0;
        usa_RP_dec = 1'b0; usa_RS_dec = 1'b0; es_load_exe = 1'b0;
        prohib_exe = 1'b0; salto_exe = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_rp(input logic [3:0] r);
        es_load_exe = 1'b1; RG_exe = r; RP_dec = r; usa_RP_dec = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        mem_req = 1'b1;
        #1;

        // Reset held two cycles with a pending memory request
        #3;
        chk1("rst_pc_en", pc_en0, 1'b0);
        chk1("rst_ifid_en", ifid_en0, 1'b0);
        chk1("rst_flush", ifid_flush0, 1'b1);
        chk1("rst_bubble", idex_bubble0, 1'b1);
        chk1("rst_freeze", freeze0, 1'b0);
        chk2("rst_estado", estado0, 2'd0);
        $display("txn reset c1: pc_en=%0b bubble=%0b estado=%0d", pc_en0, idex_bubble0, estado0);
        cyc(); #3;
        chk1("rst2_pc_en", pc_en0, 1'b0);
        chk1("rst2_bubble", idex_bubble0, 1'b1);
        chk2("rst2_estado", estado0, 2'd0);
        chk2("rst2_estado_u3", estado3, 2'd0);
        $display("txn reset c2: pc_en=%0b bubble=%0b estado=%0d", pc_en0, idex_bubble0, estado0);

        cyc(); rst_n = 1'b1; mem_req = 1'b0; #3;
        chk1("run_pc_en", pc_en0, 1'b1);
        chk1("run_ifid_en", ifid_en0, 1'b1);
        chk1("run_flush", ifid_flush0, 1'b0);
        chk1("run_bubble", idex_bubble0, 1'b0);
        chk1("run_freeze", freeze0, 1'b0);
        chk2("run_estado", estado0, 2'd0);
        $display("txn release: pc_en=%0b ifid_en=%0b", pc_en0, ifid_en0);

        // Load-use on RP with LOAD_LAT=1
        cyc(); load_rp(4'd5); #3;
        chk1("lu_pc_en", pc_en0, 1'b0);
        chk1("lu_ifid_en", ifid_en0, 1'b0);
        chk1("lu_bubble", idex_bubble0, 1'b1);
        chk1("lu_freeze", freeze0, 1'b0);
        $display("txn load-use rp: pc_en=%0b bubble=%0b", pc_en0, idex_bubble0);
        cyc(); idle(); #3;
        chk1("lu_after_pc_en", pc_en0, 1'b1);
        chk1("lu_after_bubble", idex_bubble0, 1'b0);
        chk2("lu_after_estado", estado0, 2'd0);
        $display("txn after load-use: pc_en=%0b estado=%0d", pc_en0, estado0);

        // Negative / positive RS cases
        cyc(); es_load_exe = 1'b1; prohib_exe = 1'b1; RG_exe = 4'd5; RS_dec = 4'd5; usa_RS_dec = 1'b1; #3;
        chk1("neg_prohib_pc_en", pc_en0, 1'b1);
        chk1("neg_prohib_bubble", idex_bubble0, 1'b0);
        $display("txn prohib: pc_en=%0b", pc_en0);
        cyc(); prohib_exe = 1'b0; usa_RS_dec = 1'b0; #3;
        chk1("neg_usa_rs_pc_en", pc_en0, 1'b1);
        $display("txn usa_rs=0: pc_en=%0b", pc_en0);
        cyc(); usa_RS_dec = 1'b1; #3;
        chk1("pos_rs_pc_en", pc_en0, 1'b0);
        chk1("pos_rs_bubble", idex_bubble0, 1'b1);
        $display("txn rs match: pc_en=%0b", pc_en0);
        cyc(); RS_dec = 4'd6; #3;
        chk1("neg_diff_reg_pc_en", pc_en0, 1'b1);
        $display("txn rs differs: pc_en=%0b", pc_en0);

        // Memory wait: ack low 3 cycles, then high
        cyc(); idle(); mem_req = 1'b1; #3;
        chk1("mw1_freeze", freeze0, 1'b1);
        chk1("mw1_pc_en", pc_en0, 1'b0);
        chk2("mw1_estado", estado0, 2'd0);
        $display("txn mem wait c1: freeze=%0b estado=%0d", freeze0, estado0);
        for (int i = 2; i <= 4; i++) begin
            cyc();
            if (i == 4) mem_ack = 1'b1;
            #3;
            chk1("mw_freeze", freeze0, 1'b1);
            chk1("mw_pc_en", pc_en0, 1'b0);
            chk2("mw_estado", estado0, 2'd2);
            $display("txn mem wait c%0d: freeze=%0b estado=%0d", i, freeze0, estado0);
        end
        cyc(); idle(); #3;
        chk1("mw_done_freeze", freeze0, 1'b0);
        chk1("mw_done_pc_en", pc_en0, 1'b1);
        chk2("mw_done_estado", estado0, 2'd0);
        $display("txn mem done: freeze=%0b estado=%0d", freeze0, estado0);

        // Single-cycle access
        cyc(); mem_req = 1'b1; mem_ack = 1'b1; #3;
        chk1("single_freeze", freeze0, 1'b0);
        chk1("single_pc_en", pc_en0, 1'b1);
        $display("txn single access: freeze=%0b", freeze0);
        cyc(); idle(); #3;
        chk2("single_estado", estado0, 2'd0);

        cyc(); rst_n = 1'b0; #3;
        chk1("rst_mid_pc_en3", pc_en3, 1'b0);
        cyc(); rst_n = 1'b1; #3;

        // Branch together with a load-use hazard
        cyc(); load_rp(4'd5); salto_exe = 1'b1; #3;
        chk1("br_flush", ifid_flush0, 1'b1);
        chk1("br_bubble", idex_bubble0, 1'b1);
        chk1("br_pc_en", pc_en0, 1'b1);
        chk1("br_freeze", freeze0, 1'b0);
        chk1("br_flush_u3", ifid_flush3, 1'b1);
        chk1("br_pc_en_u3", pc_en3, 1'b1);
        $display("txn branch+hz: flush=%0b bubble=%0b pc_en=%0b", ifid_flush0, idex_bubble0, pc_en0);
        cyc(); idle(); #3;
        chk2("br_after_estado_u3", estado3, 2'd0);
        chk1("br_after_pc_en_u3", pc_en3, 1'b1);

        // Reset during LOAD_STALL leaves no residual stall
        cyc(); load_rp(4'd3); #3;
        chk1("rs_hz_pc_en3", pc_en3, 1'b0);
        cyc(); idle(); #3;
        chk2("rs_ls_estado3", estado3, 2'd1);
        cyc(); rst_n = 1'b0; #3;
        chk2("rs_in_rst_estado3", estado3, 2'd0);
        cyc(); rst_n = 1'b1; #3;
        chk2("rs_post_estado3", estado3, 2'd0);
        chk1("rs_post_pc_en3", pc_en3, 1'b1);
        $display("txn reset mid-stall: estado=%0d pc_en=%0b", estado3, pc_en3);

        // LOAD_LAT=3, memory wait arriving in the 2nd stall cycle, ack on the 2nd wait cycle
        cyc(); load_rp(4'd7); #3;
        if (pc_en3 == 1'b0) n_stall++;
        chk1("l3a_bubble", idex_bubble3, 1'b1);
        chk2("l3a_estado", estado3, 2'd0);
        cyc(); idle(); mem_req = 1'b1; #3;
        if (pc_en3 == 1'b0) n_stall++;
        chk2("l3b_estado", estado3, 2'd1);
        chk1("l3b_freeze", freeze3, 1'b1);
        chk1("l3b_bubble", idex_bubble3, 1'b0);
        cyc(); mem_ack = 1'b1; #3;
        if (pc_en3 == 1'b0) n_stall++;
        chk2("l3c_estado", estado3, 2'd2);
        chk1("l3c_freeze", freeze3, 1'b1);
        cyc(); idle(); #3;
        if (pc_en3 == 1'b0) n_stall++;
        chk2("l3d_estado", estado3, 2'd1);
        chk1("l3d_bubble", idex_bubble3, 1'b1);
        chk1("l3d_freeze", freeze3, 1'b0);
        cyc(); #3;
        if (pc_en3 == 1'b0) n_stall++;
        chk2("l3e_estado", estado3, 2'd1);
        cyc(); #3;
        if (pc_en3 == 1'b0) n_stall++;
        chk2("l3f_estado", estado3, 2'd0);
        chk1("l3f_pc_en", pc_en3, 1'b1);
        chk_int("l3_stall_total", n_stall, 5);
        $display("txn load_lat3 with mem wait: stall cycles=%0d", n_stall);

        // Never-acknowledged memory request
        cyc(); rst_n = 1'b0; #3;
        cyc(); rst_n = 1'b1; #3;
        cyc(); mem_req = 1'b1; #3;
        chk1("tmo_c0_freeze", freeze3, 1'b1);
        chk1("tmo_c0_err", mem_err3, 1'b0);
`ifdef RIESGOS_MEM_TIMEOUT_EN
        for (int i = 1; i <= 4; i++) begin
            cyc(); #3;
            chk2("tmo_estado", estado3, 2'd2);
            chk1("tmo_err_pre", mem_err3, 1'b0);
            chk1("tmo_freeze", freeze3, (i < 4) ? 1'b1 : 1'b0);
            chk1("tmo_flush", ifid_flush3, (i < 4) ? 1'b0 : 1'b1);
            $display("txn timeout wait c%0d: freeze=%0b flush=%0b", i, freeze3, ifid_flush3);
        end
        cyc(); #3;
        chk1("tmo_err_set", mem_err3, 1'b1);
        chk2("tmo_estado_run", estado3, 2'd0);
        cyc(); idle(); #3;
        chk1("tmo_err_sticky", mem_err3, 1'b1);
        $display("txn timeout: mem_err=%0b", mem_err3);
`else
        repeat (8) cyc();
        #3;
        chk2("nowait_estado", estado3, 2'd2);
        chk1("nowait_err", mem_err3, 1'b0);
        chk1("nowait_freeze", freeze3, 1'b1);
        $display("txn endless wait: estado=%0d mem_err=%0b", estado3, mem_err3);
        cyc(); idle(); #3;
        chk2("nowait_drop_estado", estado3, 2'd2);
        cyc(); #3;
        chk2("nowait_run_estado", estado3, 2'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/unidad_de_riesgos.md
Name: unidad_de_riesgos

Overview:
Hazard and stall controller for the 5-stage filter-processor pipeline (IF/ID/EXE/MEM/WB). It works alongside the forwarding unit.
- Handles the cases forwarding cannot cover: load-use dependencies, multi-cycle data-memory accesses and taken branches.
- Drives the PC enable, IF/ID enable/flush, ID/EX bubble insertion and a global back-end freeze.

Parameters:
REG_W, 4, register-specifier width (16 registers)
LOAD_LAT, 1, stall cycles inserted per load-use hazard (legal 1..3)
MEM_TIMEOUT, 255, max MEM_WAIT cycles before abort (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
RP_dec  in  REG_W  first source register of instruction in ID
RS_dec  in  REG_W  second source register of instruction in ID
usa_RP_dec  in  1  ID instruction reads RP
usa_RS_dec  in  1  ID instruction reads RS
RG_exe  in  REG_W  destination register of instruction in EXE
es_load_exe  in  1  EXE instruction is a load
prohib_exe  in  1  EXE instruction does not write RG
salto_exe  in  1  branch/jump taken, resolved in EXE
mem_req  in  1  MEM-stage instruction is accessing data memory
mem_ack  in  1  data memory completes access this cycle
pc_en  out  1  PC register load enable
ifid_en  out  1  IF/ID register enable
ifid_flush  out  1  load NOP into IF/ID
idex_bubble  out  1  load NOP into ID/EX
freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
estado  out  2  current FSM state (debug)
mem_err  out  1  sticky memory-timeout flag (optional feature)

Behaviour:
- State register, LOAD_STALL counter (2 bits) and timeout counter update on the rising clk edge. All outputs are combinational from state and inputs.
- States: RUN=0, LOAD_STALL=1, MEM_WAIT=2.
- Reset (rst_n=0 at a clock edge):
  - State=RUN, counters=0, mem_err=0.
  - While rst_n=0: pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1, freeze=0, estado=0.
  - Reset mid-stall or mid-wait aborts to RUN with no residual stall.
- Hazard term hz = es_load_exe & ~prohib_exe & ((usa_RP_dec & RP_dec==RG_exe) | (usa_RS_dec & RS_dec==RG_exe)).
- Memory term mw = mem_req & ~mem_ack.
- Priority each cycle: mw > salto_exe > hz.
- RUN:
  - mw: freeze=1, pc_en=0, ifid_en=0, next MEM_WAIT.
  - else salto_exe: ifid_flush=1, idex_bubble=1, pc_en=1, stay RUN. A branch overrides hz, because the dependent instruction is flushed.
  - else hz: pc_en=0, ifid_en=0, idex_bubble=1, cnt=LOAD_LAT-1. If LOAD_LAT>1, next LOAD_STALL; else stay RUN.
  - else: pc_en=1, ifid_en=1, all others 0.
- LOAD_STALL:
  - pc_en=0, ifid_en=0, idex_bubble=1.
  - cnt decrements each cycle; at cnt==1 the next state is RUN.
  - mw in this state: freeze=1 and idex_bubble=0; cnt pauses; next MEM_WAIT; resume LOAD_STALL after ack.
  - salto_exe is impossible here (EXE holds a bubble) and is ignored.
- MEM_WAIT:
  - freeze=1, pc_en=0, ifid_en=0, bubble=0, flush=0.
  - On mem_ack=1, freeze is still 1 that cycle. Next state is RUN, or LOAD_STALL if paused cnt≠0.
  - mem_req dropping without ack: return to RUN next cycle (protocol violation, no error).
- mem_req & mem_ack in the same cycle: single-cycle access, no freeze.
- Register-0 is not special-cased; the decoder clears usa_* for r0.

Optional Feature:
RIESGOS_MEM_TIMEOUT_EN:
- Defined: an 8-bit counter counts MEM_WAIT cycles. On reaching MEM_TIMEOUT, mem_err is set (sticky until reset), the FSM goes to RUN, and that cycle asserts ifid_flush=1, idex_bubble=1, freeze=0.
- Undefined: MEM_WAIT waits indefinitely; mem_err tied 0; no counter logic.

Decomposition:
- Package riesgos_pkg holds the state encoding constants (RUN/LOAD_STALL/MEM_WAIT), default REG_W, and the NOP-control constant.
- One natural sub-module: detector_dependencia, a combinational comparator producing hz from the source/destination specifiers, usa_* bits and prohib_exe.

Test Plan:
- Reset: rst_n=0 for 2 cycles with mem_req=1 -> pc_en=0, idex_bubble=1, estado=0; after release with no hazards -> pc_en=1, ifid_en=1.
- Load-use, LOAD_LAT=1: es_load_exe=1, RG_exe=5, RP_dec=5, usa_RP_dec=1 -> one cycle pc_en=0, idex_bubble=1; next cycle, with es_load_exe=0, pc_en=1.
- Load-use negatives:
  - prohib_exe=1, RG_exe=5, RS_dec=5 -> no stall.
  - usa_RS_dec=0 -> no stall.
- Memory wait: mem_req=1, mem_ack low 3 cycles then high -> freeze=1 for 4 cycles, estado=2 for 3 cycles, RUN after.
- Branch with simultaneous hazard: salto_exe=1 and hz=1 -> ifid_flush=1, idex_bubble=1, pc_en=1, no LOAD_STALL.
- LOAD_LAT=3 with mem_req arriving in the 2nd stall cycle, ack after 2 cycles -> stall resumes, total pc_en=0 for 5 cycles. With RIESGOS_MEM_TIMEOUT_EN and MEM_TIMEOUT=4, never-acked mem_req -> mem_err=1 after 4 wait cycles, estado returns to 0.
